// File: rtl/uart_mmio_if.sv
// Bus port between the core's data-memory stage and the UART peripheral.
// The core drives the access signals; the peripheral returns read data in the same cycle.
interface uart_mmio_if;
    logic        Sel;
    logic        Hold;
    logic        MemRead;
    logic [3:0]  MemWrite;
    logic [3:0]  Addr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;

    modport master (
        output Sel, Hold, MemRead, MemWrite, Addr, WriteData,
        input  ReadData
    );

    modport slave (
        input  Sel, Hold, MemRead, MemWrite, Addr, WriteData,
        output ReadData
    );
endinterface

// File: rtl/uart_mmio.sv
// Memory-mapped UART: TX FIFO and serialiser, RX deserialiser with a one-byte holding
// register, and a status register with write-1-to-clear sticky error bits.
module uart_mmio #(
    parameter int CLKS_PER_BIT = 868,
    parameter int TX_DEPTH     = 16
) (
    input  logic        CLK,
    input  logic        RESET,
    uart_mmio_if.slave  bus,
    output logic        TX,
    input  logic        RX
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(TX_DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic       acc;
    logic [1:0] reg_sel;
    logic       push_req, clr_req, rx_pop;

    assign acc      = bus.Sel & ~bus.Hold;
    assign reg_sel  = bus.Addr[3:2];
    assign push_req = acc & bus.MemWrite[0] & (reg_sel == 2'd0);
    assign clr_req  = acc & bus.MemWrite[0] & (reg_sel == 2'd2);
    assign rx_pop   = acc & bus.MemRead & (reg_sel == 2'd1);

    logic unused_bits;
    assign unused_bits = &{1'b0, bus.WriteData[31:8], bus.MemWrite[3:1], bus.Addr[1:0]};

    // ---------------- TX FIFO ----------------
    logic [7:0]  fifo_mem [TX_DEPTH];
    logic [AW:0] wr_ptr_reg, rd_ptr_reg;
    logic        fifo_empty, fifo_full, push_ok, overflow_set, tx_pop;

    assign fifo_empty   = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                          (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    // A push into a full FIFO is refused even if the serialiser pops in the same cycle.
    assign push_ok      = push_req & ~fifo_full;
    assign overflow_set = push_req & fifo_full;

    always_ff @(posedge CLK) begin
        if (push_ok)
            fifo_mem[wr_ptr_reg[AW-1:0]] <= bus.WriteData[7:0];
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (tx_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    // ---------------- TX serialiser ----------------
    state_t          tx_state_reg;
    logic [CW-1:0]   tx_cnt_reg;
    logic [2:0]      tx_bit_reg;
    logic [7:0]      tx_shift_reg;
    logic            tx_reg;
    logic            tx_idle;

    assign tx_pop  = ~fifo_empty & ((tx_state_reg == S_IDLE) |
                     ((tx_state_reg == S_STOP) & (tx_cnt_reg == CNT_LAST)));
    assign tx_idle = fifo_empty & (tx_state_reg == S_IDLE);
    assign TX      = tx_reg;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            tx_state_reg <= S_IDLE;
            tx_cnt_reg   <= '0;
            tx_bit_reg   <= '0;
            tx_shift_reg <= '0;
            tx_reg       <= 1'b1;
        end else begin
            case (tx_state_reg)
                S_IDLE: begin
                    tx_reg <= 1'b1;
                    if (tx_pop) begin
                        tx_state_reg <= S_START;
                        tx_shift_reg <= fifo_mem[rd_ptr_reg[AW-1:0]];
                        tx_cnt_reg   <= '0;
                        tx_reg       <= 1'b0;
                    end
                end
                S_START: begin
                    if (tx_cnt_reg == CNT_LAST) begin
                        tx_cnt_reg   <= '0;
                        tx_bit_reg   <= '0;
                        tx_state_reg <= S_DATA;
                        tx_reg       <= tx_shift_reg[0];
                    end else begin
                        tx_cnt_reg <= tx_cnt_reg + 1'b1;
                    end
                end
                S_DATA: begin
                    if (tx_cnt_reg == CNT_LAST) begin
                        tx_cnt_reg <= '0;
                        if (tx_bit_reg == 3'd7) begin
                            tx_state_reg <= S_STOP;
                            tx_reg       <= 1'b1;
                        end else begin
                            tx_bit_reg   <= tx_bit_reg + 1'b1;
                            tx_shift_reg <= {1'b0, tx_shift_reg[7:1]};
                            tx_reg       <= tx_shift_reg[1];
                        end
                    end else begin
                        tx_cnt_reg <= tx_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    if (tx_cnt_reg == CNT_LAST) begin
                        tx_cnt_reg <= '0;
                        // Chain straight into the next frame so there is no idle gap.
                        if (tx_pop) begin
                            tx_state_reg <= S_START;
                            tx_shift_reg <= fifo_mem[rd_ptr_reg[AW-1:0]];
                            tx_reg       <= 1'b0;
                        end else begin
                            tx_state_reg <= S_IDLE;
                        end
                    end else begin
                        tx_cnt_reg <= tx_cnt_reg + 1'b1;
                    end
                end
            endcase
        end
    end

    // ---------------- RX deserialiser ----------------
    logic            rx_meta_reg, rx_sync_reg, rx_prev_reg;
    state_t          rx_state_reg;
    logic [CW-1:0]   rx_cnt_reg;
    logic [2:0]      rx_bit_reg;
    logic [7:0]      rx_shift_reg;
    logic            rx_stop_done, deliver, frame_bad;

    assign rx_stop_done = (rx_state_reg == S_STOP) & (rx_cnt_reg == CNT_LAST);
    assign deliver      = rx_stop_done & rx_sync_reg;
    assign frame_bad    = rx_stop_done & ~rx_sync_reg;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            rx_meta_reg  <= 1'b1;
            rx_sync_reg  <= 1'b1;
            rx_prev_reg  <= 1'b1;
            rx_state_reg <= S_IDLE;
            rx_cnt_reg   <= '0;
            rx_bit_reg   <= '0;
            rx_shift_reg <= '0;
        end else begin
            rx_meta_reg <= RX;
            rx_sync_reg <= rx_meta_reg;
            rx_prev_reg <= rx_sync_reg;
            case (rx_state_reg)
                S_IDLE: begin
                    if (rx_prev_reg & ~rx_sync_reg) begin
                        rx_state_reg <= S_START;
                        rx_cnt_reg   <= '0;
                    end
                end
                S_START: begin
                    // Mid-bit re-check rejects short glitches without flagging anything.
                    if (rx_cnt_reg == CNT_HALF) begin
                        rx_cnt_reg   <= '0;
                        rx_bit_reg   <= '0;
                        rx_state_reg <= rx_sync_reg ? S_IDLE : S_DATA;
                    end else begin
                        rx_cnt_reg <= rx_cnt_reg + 1'b1;
                    end
                end
                S_DATA: begin
                    if (rx_cnt_reg == CNT_LAST) begin
                        rx_cnt_reg   <= '0;
                        rx_shift_reg <= {rx_sync_reg, rx_shift_reg[7:1]};
                        if (rx_bit_reg == 3'd7) rx_state_reg <= S_STOP;
                        else                    rx_bit_reg   <= rx_bit_reg + 1'b1;
                    end else begin
                        rx_cnt_reg <= rx_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    if (rx_cnt_reg == CNT_LAST) begin
                        rx_cnt_reg   <= '0;
                        rx_state_reg <= S_IDLE;
                    end else begin
                        rx_cnt_reg <= rx_cnt_reg + 1'b1;
                    end
                end
            endcase
        end
    end

    // ---------------- RX holding register and sticky status ----------------
    logic       rx_valid_reg;
    logic [7:0] rx_byte_reg;
    logic       overrun_set;
    logic [2:0] sticky_set, sticky;

    assign overrun_set = deliver & rx_valid_reg & ~rx_pop;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            rx_valid_reg <= 1'b0;
            rx_byte_reg  <= '0;
        end else if (deliver & ~overrun_set) begin
            rx_valid_reg <= 1'b1;
            rx_byte_reg  <= rx_shift_reg;
        end else if (rx_pop) begin
            rx_valid_reg <= 1'b0;
        end
    end

    // Order matches STATUS[5:3]: overrun, overflow, frame error.
    assign sticky_set = {frame_bad, overflow_set, overrun_set};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sticky
            logic bit_reg;
            always_ff @(posedge CLK) begin
                if (RESET)
                    bit_reg <= 1'b0;
                else if (sticky_set[gi])
                    bit_reg <= 1'b1;
                else if (clr_req & bus.WriteData[3+gi])
                    bit_reg <= 1'b0;
            end
            assign sticky[gi] = bit_reg;
        end
    endgenerate

    always_comb begin
        bus.ReadData = '0;
        if (bus.Sel) begin
            case (reg_sel)
                2'd1:    bus.ReadData = {24'b0, rx_byte_reg};
                2'd2:    bus.ReadData = {26'b0, sticky, tx_idle, fifo_full, rx_valid_reg};
                default: bus.ReadData = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_mmio.sv
// Self-checking bench for uart_mmio: TX frames checked through a scoreboard queue,
// RX bytes checked on RXDATA reads, STATUS compared against a small reference model.
module tb_uart_mmio;
    localparam int CPB = 4;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    logic RX = 1'b1;
    logic TX;

    uart_mmio_if bus ();

    uart_mmio #(.CLKS_PER_BIT(CPB), .TX_DEPTH(16)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus),
        .TX    (TX),
        .RX    (RX)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad = 0;
    int frames = 0;
    logic [7:0] tx_exp[$];
    logic [7:0] rx_exp[$];

    // Reference model of the RX/status side
    logic m_valid = 1'b0, m_ovr = 1'b0, m_ovf = 1'b0, m_frame = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    function automatic logic [31:0] exp_status(input logic full, input logic idle);
        return {26'b0, m_frame, m_ovf, m_ovr, idle, full, m_valid};
    endfunction

    // TX monitor: decode frames at mid-bit and compare against the scoreboard
    initial begin
        logic       mon_in;
        int         mon_pos;
        logic [7:0] mon_byte;
        logic [7:0] exp_b;
        mon_in = 1'b0;
        mon_pos = 0;
        mon_byte = '0;
        forever begin
            @(negedge CLK);
            if (RESET) begin
                mon_in = 1'b0;
            end else if (!mon_in) begin
                if (TX === 1'b0) begin
                    mon_in = 1'b1;
                    mon_pos = 0;
                end
            end else begin
                mon_pos++;
                if (mon_pos >= 6 && mon_pos <= 34 && ((mon_pos - 6) % 4) == 0)
                    mon_byte[(mon_pos - 6) / 4] = TX;
                if (mon_pos == 38) begin
                    mon_in = 1'b0;
                    frames++;
                    check_val("tx_stop_bit", {31'b0, TX}, 32'd1);
                    check_val("tx_frame_expected", {31'b0, tx_exp.size() > 0}, 32'd1);
                    if (tx_exp.size() > 0) begin
                        exp_b = tx_exp.pop_front();
                        check_val("tx_byte", {24'b0, mon_byte}, {24'b0, exp_b});
                    end
                end
            end
        end
    end

    task automatic bus_idle();
        bus.Sel = 1'b0;
        bus.Hold = 1'b0;
        bus.MemRead = 1'b0;
        bus.MemWrite = 4'h0;
        bus.Addr = 4'h0;
        bus.WriteData = 32'h0;
    endtask

    task automatic bus_write(input logic [3:0] addr, input logic [31:0] data, input logic hold);
        @(negedge CLK);
        bus.Sel = 1'b1;
        bus.Hold = hold;
        bus.MemWrite = 4'hF;
        bus.Addr = addr;
        bus.WriteData = data;
        @(posedge CLK);
        #1 bus_idle();
    endtask

    task automatic bus_read(input logic [3:0] addr, input logic hold, output logic [31:0] data);
        @(negedge CLK);
        bus.Sel = 1'b1;
        bus.Hold = hold;
        bus.MemRead = 1'b1;
        bus.Addr = addr;
        #1 data = bus.ReadData;
        @(posedge CLK);
        #1 bus_idle();
    endtask

    task automatic push_tx(input logic [7:0] b, input logic accepted);
        bus_write(4'h0, {24'b0, b}, 1'b0);
        if (accepted) tx_exp.push_back(b);
    endtask

    task automatic rx_bit(input logic v);
        RX = v;
        repeat (CPB) @(posedge CLK);
        #1;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        @(posedge CLK);
        #1;
        rx_bit(1'b0);
        for (int i = 0; i < 8; i++) rx_bit(b[i]);
        rx_bit(stop_bit);
        RX = 1'b1;
        repeat (6) @(posedge CLK);
        #1;
        if (!stop_bit) begin
            m_frame = 1'b1;
        end else if (m_valid) begin
            m_ovr = 1'b1;
        end else begin
            m_valid = 1'b1;
            rx_exp.push_back(b);
        end
    endtask

    task automatic read_rx(input string tag);
        logic [31:0] d;
        logic [7:0]  e;
        bus_read(4'h4, 1'b0, d);
        check_val({tag, "_queued"}, {31'b0, rx_exp.size() > 0}, 32'd1);
        if (rx_exp.size() > 0) begin
            e = rx_exp.pop_front();
            check_val(tag, d, {24'b0, e});
        end
        m_valid = 1'b0;
    endtask

    task automatic check_status(input string tag, input logic full, input logic idle);
        logic [31:0] d;
        bus_read(4'h8, 1'b0, d);
        check_val(tag, d, exp_status(full, idle));
    endtask

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] d;
        int          f0;
        int          err;
        bus_idle();
        RESET = 1'b1;
        repeat (3) @(posedge CLK);
        #1 RESET = 1'b0;

        // Reset state
        check_status("status_after_reset", 1'b0, 1'b1);
        bus_read(4'h4, 1'b0, d);
        check_val("rxdata_after_reset", d, 32'h0);
        bus_read(4'hC, 1'b0, d);
        check_val("reserved_reads_zero", d, 32'h0);
        err = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (TX !== 1'b1) err++;
        end
        check_val("tx_idle_high_100", err, 0);

        // Single frame: latency, length, idle return
        push_tx(8'h55, 1'b1);
        check_val("tx_at_push_edge", {31'b0, TX}, 32'd1);
        @(posedge CLK);
        #1 check_val("tx_low_after_e1", {31'b0, TX}, 32'd0);
        repeat (39) @(posedge CLK);
        #1;
        check_status("busy_before_e41", 1'b0, 1'b0);
        check_status("idle_after_e41", 1'b0, 1'b1);

        // Store with Hold has no effect
        bus_write(4'h0, 32'h000000AA, 1'b1);
        repeat (5) @(posedge CLK);
        #1 check_status("hold_write_ignored", 1'b0, 1'b1);

        // FIFO fill and overflow while a frame is in progress
        f0 = frames;
        push_tx(8'hA5, 1'b1);
        for (int i = 0; i < 17; i++) begin
            push_tx(8'($urandom_range(0, 255)), i < 16);
            if (i == 15) check_status("tx_full_at_16", 1'b1, 1'b0);
        end
        m_ovf = 1'b1;
        check_status("tx_overflow_set", 1'b1, 1'b0);
        bus_write(4'h8, 32'h00000010, 1'b0);
        m_ovf = 1'b0;
        check_status("tx_overflow_cleared", 1'b1, 1'b0);
        for (int c = 0; c < 1000 && (frames - f0) < 17; c++) @(posedge CLK);
        repeat (100) @(posedge CLK);
        #1;
        check_val("frames_emitted", frames - f0, 17);
        check_val("tx_queue_drained", tx_exp.size(), 0);
        check_status("idle_after_burst", 1'b0, 1'b1);

        // RX single byte, Hold read, real read
        send_rx(8'hA3, 1'b1);
        check_status("rx_valid_set", 1'b0, 1'b1);
        bus_read(4'h4, 1'b1, d);
        check_val("rxdata_hold_read", d, 32'h000000A3);
        check_status("rx_valid_kept_on_hold", 1'b0, 1'b1);
        read_rx("rxdata_a3");
        check_status("rx_valid_cleared", 1'b0, 1'b1);

        // Overrun
        send_rx(8'h3C, 1'b1);
        send_rx(8'hC5, 1'b1);
        check_status("rx_overrun_set", 1'b0, 1'b1);
        read_rx("rxdata_keeps_first");

        // Frame error with a byte already held
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b0);
        check_status("rx_frame_err_set", 1'b0, 1'b1);
        bus_write(4'h8, 32'h00000038, 1'b0);
        m_ovr = 1'b0;
        m_frame = 1'b0;
        check_status("sticky_cleared", 1'b0, 1'b1);
        read_rx("rxdata_11");

        // Reset in the middle of a TX frame
        push_tx(8'h0F, 1'b1);
        repeat (10) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        tx_exp.delete();
        @(posedge CLK);
        #1 check_val("tx_high_after_reset", {31'b0, TX}, 32'd1);
        @(posedge CLK);
        #1 RESET = 1'b0;
        check_status("status_after_mid_reset", 1'b0, 1'b1);
        f0 = frames;
        err = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK);
            if (TX !== 1'b1) err++;
        end
        check_val("no_resume_after_reset", err, 0);
        check_val("no_frames_after_reset", frames - f0, 0);
        check_val("rx_queue_empty", rx_exp.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_mmio.md
# uart_mmio

Memory-mapped UART peripheral that sits directly downstream of the core's data-memory port. It consumes the M-stage access signals (read enable, byte-write mask, address, aligned write data) and returns combinational read data to the core's load path in the same cycle. It contains a 16-entry TX FIFO with a serialiser, and an RX deserialiser with a single-entry holding register. It also provides a status register with sticky error bits.

## Interface
- CLKS_PER_BIT, default 868: clock cycles per UART bit (100 MHz / 115200); must be ≥ 4.
- TX_DEPTH, default 16: TX FIFO entries; power of two.
- CLK  in  1  clock, rising-edge.
- RESET  in  1  synchronous, active-high reset.
- Sel  in  1  address decode hit for this peripheral (from the core's M-stage address).
- Hold  in  1  M stage frozen (tie to the multi-cycle Busy); suppresses all side effects.
- MemRead  in  1  load in M stage.
- MemWrite  in  4  byte-enable mask of the store.
- Addr  in  4  byte offset within the peripheral; only [3:2] decoded.
- WriteData  in  32  aligned store data.
- ReadData  out  32  combinational read data; 0 when Sel=0.
- TX  out  1  serial out, idle high.
- RX  in  1  serial in, asynchronous.

## Operation
- Register map (Addr[3:2]):
  - 0 = TXDATA (write-only; reads 0).
  - 1 = RXDATA (read: {24'b0, rx_byte}).
  - 2 = STATUS.
  - 3 = reserved (reads 0, writes ignored).
- STATUS bits: [0] rx_valid, [1] tx_full, [2] tx_idle (FIFO empty and TX FSM IDLE), [3] rx_overrun, [4] tx_overflow, [5] rx_frame_err; [31:6] = 0.
- Access qualification: "acc" = Sel & ~Hold. No read or write has any side effect while Hold=1.
- Push: acc & MemWrite[0] & Addr[3:2]==0 pushes WriteData[7:0].
  - When the FIFO is full, the push is refused and tx_overflow is set. This applies even if the FSM pops in the same cycle.
- Pop RX: acc & MemRead & Addr[3:2]==1 clears rx_valid at the edge. ReadData shows the pre-edge byte.
- Clear: acc & MemWrite[0] & Addr[3:2]==2. Each 1 in WriteData[5:3] clears the corresponding sticky bit (write-1-to-clear). Other bits are ignored.
- TX FSM: IDLE → START → DATA → STOP → IDLE (or → START if the FIFO is non-empty).
  - Each state holds for CLKS_PER_BIT cycles.
  - DATA shifts 8 bits LSB first.
  - The FIFO head is popped on the IDLE/STOP→START transition.
  - TX = 0 in START, the data bit in DATA, 1 in STOP/IDLE.
- RX path:
  - RX passes through a 2-flop synchroniser.
  - RX FSM: IDLE → START → DATA → STOP → IDLE.
  - A synchronised falling edge in IDLE enters START. START waits CLKS_PER_BIT/2 cycles and re-samples the line; if the line is high, the FSM returns to IDLE as a glitch and nothing is flagged.
  - Data bits and the stop bit are then sampled every CLKS_PER_BIT cycles.
  - Stop bit = 1: the byte is delivered to the holding register.
  - Stop bit = 0: the byte is discarded and rx_frame_err is set.
- Delivery while rx_valid=1 and no pop in the same cycle: the new byte is discarded, the old byte is kept, and rx_overrun is set.
- Delivery coinciding with a pop: the new byte is stored, rx_valid stays 1, and no overrun is flagged.
- Counter widths: $clog2(CLKS_PER_BIT) bit counter, 3-bit bit index, $clog2(TX_DEPTH)+1 FIFO pointers. Pointers wrap modulo 2·TX_DEPTH; full/empty are derived from the MSB compare.

## Timing
- Reset values: TX=1; both FSMs IDLE; FIFO empty; rx_valid=0; rx_byte=0; all sticky bits 0.
  - ReadData depends only on inputs and these registers, so STATUS reads 0x04 after reset.
- Reset mid-frame: at the reset edge TX returns to 1, FIFO contents are dropped, and any partial RX byte is discarded.
- ReadData is combinational: valid in the same cycle as Sel/MemRead/Addr, with no added latency.
- TX latency: push at edge E (FIFO was empty, FSM IDLE) → TX goes low after edge E+1.
  - Each frame is exactly 10·CLKS_PER_BIT cycles.
  - Back-to-back frames have no idle gap.
- tx_full is asserted from the edge at which the TX_DEPTH-th unpopped entry is written.
- RX latency: rx_valid rises at the edge that samples the stop bit, about 9.5·CLKS_PER_BIT + 2 cycles after the line falls.
- Sticky set and clear in the same cycle: set wins.

## Test plan
- Reset, then read STATUS → 0x00000004; TX held at 1 for 100 cycles.
- CLKS_PER_BIT=4, store 0x55 to offset 0 → TX low after E+1, then bits 1,0,1,0,1,0,1,0, then stop; 40 cycles total; STATUS bit2 returns to 1.
- Push 17 bytes with no Hold while the first frame is still in progress → tx_full=1 after the 17th push, which is refused; tx_overflow=1; exactly 17 frames emitted. Then write 0x10 to STATUS → bit4 clears.
- Drive RX frame 0xA3 → rx_valid=1; RXDATA reads 0xA3; read with Hold=1 leaves rx_valid=1; read with Hold=0 clears it.
- Two RX frames without a read → rx_overrun=1 and RXDATA keeps the first byte. A frame with stop=0 → rx_frame_err=1 and rx_valid unchanged.
- Assert RESET in the middle of a TX frame → TX=1 at the next edge; STATUS reads 0x04; the FIFO does not resume transmitting.
